// File: rtl/phys_reg_free_list.sv
// Physical-register free pool: circular FIFO of free tags (show-ahead allocate)
// with a per-tag free bitmap that filters out preg 0 and double-frees on release.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = 6,
  parameter int ARCH_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_preg,
  input  logic              release_valid,
  input  logic [PREG_W-1:0] release_preg,
  output logic [PREG_W:0]   free_count,
  output logic              err_double_free
);

  localparam int INIT_FREE = NUM_PREGS - ARCH_REGS;

  logic [NUM_PREGS-1:0][PREG_W-1:0] fifo_q;
  logic [PREG_W-1:0]                head_q, head_d;
  logic [PREG_W-1:0]                tail_q, tail_d;
  logic [PREG_W:0]                  count_q, count_d;
  logic [NUM_PREGS-1:0]             bitmap_q, bitmap_d;
  logic                             err_q, err_d;

  logic pop, rel_nz, rel_acc, rel_dbl;

  assign alloc_valid     = (count_q != '0);
  assign alloc_preg      = fifo_q[head_q];
  assign free_count      = count_q;
  assign err_double_free = err_q;

  // The bitmap is sampled pre-edge, so releasing the tag being popped this
  // cycle sees it still free and is treated as a double-free.
  assign pop     = alloc_req && alloc_valid;
  assign rel_nz  = release_valid && (release_preg != '0);
  assign rel_acc = rel_nz && !bitmap_q[release_preg];
  assign rel_dbl = rel_nz &&  bitmap_q[release_preg];

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    bitmap_d = bitmap_q;
    err_d    = err_q | rel_dbl;
    if (pop) begin
      head_d               = head_q + 1'b1;
      bitmap_d[alloc_preg] = 1'b0;
    end
    if (rel_acc) begin
      tail_d                 = tail_q + 1'b1;
      bitmap_d[release_preg] = 1'b1;
    end
    unique case ({rel_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo_q[i]   <= (i < INIT_FREE) ? PREG_W'(ARCH_REGS + i) : '0;
        bitmap_q[i] <= (i >= ARCH_REGS);
      end
      head_q  <= '0;
      tail_q  <= PREG_W'(INIT_FREE);
      count_q <= (PREG_W+1)'(INIT_FREE);
      err_q   <= 1'b0;
    end else begin
      if (rel_acc) fifo_q[tail_q] <= release_preg;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized bench for phys_reg_free_list against a queue/set model of the pool.
module tb_phys_reg_free_list;
  localparam int NP = 64, PW = 6, AR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_req, alloc_valid;
  logic [PW-1:0] alloc_preg;
  logic          release_valid;
  logic [PW-1:0] release_preg;
  logic [PW:0]   free_count;
  logic          err_double_free;

  phys_reg_free_list #(.NUM_PREGS(NP), .PREG_W(PW), .ARCH_REGS(AR)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .release_valid(release_valid), .release_preg(release_preg),
    .free_count(free_count), .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  // Reference: ordered queue of free tags plus a set of which tags are free.
  int q[$];
  bit fr[NP];
  bit merr;
  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    merr = 1'b0;
    for (int i = 0; i < NP; i++) fr[i] = (i >= AR);
    for (int i = AR; i < NP; i++) q.push_back(i);
  endtask

  task automatic check_all();
    chk("alloc_valid", 32'(alloc_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("alloc_preg", 32'(alloc_preg), 32'(q[0]));
    chk("free_count", 32'(free_count), 32'(q.size()));
    chk("err_double_free", 32'(err_double_free), 32'(merr));
  endtask

  // Called at a negedge: drive inputs, model the edge, check after it.
  task automatic step(input bit req, input bit rv, input int rp);
    bit pop, acc;
    alloc_req     = req;
    release_valid = rv;
    release_preg  = PW'(rp);
    @(posedge clk);
    pop = req && (q.size() != 0);
    acc = rv && (rp != 0) && !fr[rp];
    if (rv && rp != 0 && fr[rp]) merr = 1'b1;
    if (pop) begin
      fr[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(rp);
      fr[rp] = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick_rp();
    int r, t;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(0, NP-1);
    if (r == 2 && q.size() != 0) return q[0];
    for (int k = 0; k < 64; k++) begin
      t = $urandom_range(1, NP-1);
      if (!fr[t]) return t;
    end
    return $urandom_range(1, NP-1);
  endfunction

  initial begin
    alloc_req = 0; release_valid = 0; release_preg = '0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // drain the pool, then one extra ignored request
    repeat (33) step(1, 0, 0);
    // release into empty pool alongside a request: no bypass
    step(1, 1, 5);
    step(0, 0, 0);
    mid_reset();

    step(0, 1, 40);   // already free -> double-free
    step(0, 0, 0);
    step(0, 1, 0);    // preg 0 ignored
    repeat (40) step(1, 1, 7);
    mid_reset();

    repeat (3) step(1, 0, 0);
    mid_reset();

    for (int ph = 0; ph < 6; ph++) begin
      int preq, prel;
      case (ph % 3)
        0: begin preq = 85; prel = 30; end
        1: begin preq = 10; prel = 95; end
        default: begin preq = 50; prel = 50; end
      endcase
      for (int n = 0; n < 250; n++)
        step($urandom_range(0, 99) < preq, $urandom_range(0, 99) < prel, pick_rp());
      if (ph == 3) mid_reset();
    end

    // fill completely, then any release must be a double-free
    for (int t = 1; t < NP; t++) if (!fr[t]) step(0, 1, t);
    chk("full_count", 32'(free_count), 32'(NP-1));
    step(0, 1, $urandom_range(1, NP-1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
